// File: rtl/refill_rd_arbiter_if.sv
// Refill read-port interface: request (req/type/addr/rdy) plus single-beat
// return (ret_valid/ret_data). The master issues requests; the slave accepts
// them and supplies the return. The arbiter is a slave towards each cache and
// a master towards the AXI bridge.
interface refill_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256
);
  logic              rd_req;
  logic              rd_type;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic [DATA_W-1:0] ret_data;

  modport master (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_data
  );

  modport slave (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_data
  );
endinterface

// File: rtl/refill_rd_arbiter.sv
// Shares the single 256-bit refill read port between the icache and the
// data-side path. One outstanding read at a time; the grant is locked from
// request issue until the return beat, which is routed to the owner only.
// Default arbitration is fixed priority (DC over IC). Defining the macro
// REFILL_ARB_RR_EN switches ties to round-robin via a last_grant register.
module refill_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  refill_rd_arbiter_if.slave   ic,
  refill_rd_arbiter_if.slave   dc,
  refill_rd_arbiter_if.master  axi,
  output logic [CNT_W-1:0]     ic_grant_cnt,
  output logic [CNT_W-1:0]     dc_grant_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  ic_cnt_q, ic_cnt_d;
  logic [CNT_W-1:0]  dc_cnt_q, dc_cnt_d;
`ifdef REFILL_ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic              winner;
  logic              sel;
  logic              req_out;
  logic              ic_rdy, dc_rdy;
  logic              ic_rv, dc_rv;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_type;
  logic [DATA_W-1:0] ret_data;

  // Arbitration among current requesters (only consulted in IDLE)
  always_comb begin
    winner = dc.rd_req ? OWN_DC : OWN_IC;
`ifdef REFILL_ARB_RR_EN
    if (ic.rd_req && dc.rd_req) begin
      winner = ~last_grant_q;
    end
`endif
  end

  // FSM next-state, grant routing and return steering
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel     = owner_q;
    req_out = 1'b0;
    ic_rdy  = 1'b0;
    dc_rdy  = 1'b0;
    ic_rv   = 1'b0;
    dc_rv   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ic.rd_req || dc.rd_req) begin
          sel     = winner;
          owner_d = winner;
          req_out = 1'b1;
          state_d = axi.rd_rdy ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        req_out = 1'b1;
        if (axi.rd_rdy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (axi.ret_valid) begin
          ic_rv   = (owner_q == OWN_IC);
          dc_rv   = (owner_q == OWN_DC);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (req_out) begin
      ic_rdy = (sel == OWN_IC) && axi.rd_rdy;
      dc_rdy = (sel == OWN_DC) && axi.rd_rdy;
    end

    // Outputs are forced quiet for the whole reset cycle, whatever the state
    if (!resetn) begin
      req_out = 1'b0;
      ic_rdy  = 1'b0;
      dc_rdy  = 1'b0;
      ic_rv   = 1'b0;
      dc_rv   = 1'b0;
    end
  end

  // Grant counters and last-grant tracking, stepped on each downstream accept
  always_comb begin
    ic_cnt_d = ic_cnt_q;
    dc_cnt_d = dc_cnt_q;
    if (ic_rdy) begin
      ic_cnt_d = ic_cnt_q + CNT_W'(1);
    end
    if (dc_rdy) begin
      dc_cnt_d = dc_cnt_q + CNT_W'(1);
    end
`ifdef REFILL_ARB_RR_EN
    last_grant_d = last_grant_q;
    if (ic_rdy || dc_rdy) begin
      last_grant_d = sel;
    end
`endif
  end

  // Owner request pass-through and return data fan-out
  always_comb begin
    sel_addr = (sel == OWN_DC) ? dc.rd_addr : ic.rd_addr;
    sel_type = (sel == OWN_DC) ? dc.rd_type : ic.rd_type;
    ret_data = axi.ret_data;
  end

  assign axi.rd_req    = req_out;
  assign axi.rd_type   = sel_type;
  assign axi.rd_addr   = sel_addr;
  assign ic.rd_rdy     = ic_rdy;
  assign dc.rd_rdy     = dc_rdy;
  assign ic.ret_valid  = ic_rv;
  assign dc.ret_valid  = dc_rv;
  assign ic.ret_data   = ret_data;
  assign dc.ret_data   = ret_data;
  assign ic_grant_cnt  = ic_cnt_q;
  assign dc_grant_cnt  = dc_cnt_q;

  // State, owner and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IC;
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ic_cnt_q <= ic_cnt_d;
      dc_cnt_q <= dc_cnt_d;
    end
  end

`ifdef REFILL_ARB_RR_EN
  // Round-robin history register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_q <= OWN_IC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_refill_rd_arbiter.sv
// Directed bench for refill_rd_arbiter. A second, narrow-counter instance is
// used to exercise counter wrap-around within a few accepts.
module tb_refill_rd_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  refill_rd_arbiter_if #(.ADDR_W(32), .DATA_W(256)) ic_if ();
  refill_rd_arbiter_if #(.ADDR_W(32), .DATA_W(256)) dc_if ();
  refill_rd_arbiter_if #(.ADDR_W(32), .DATA_W(256)) axi_if ();
  logic [31:0] ic_cnt, dc_cnt;

  refill_rd_arbiter #(.ADDR_W(32), .DATA_W(256), .CNT_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ic           (ic_if),
    .dc           (dc_if),
    .axi          (axi_if),
    .ic_grant_cnt (ic_cnt),
    .dc_grant_cnt (dc_cnt)
  );

  refill_rd_arbiter_if #(.ADDR_W(32), .DATA_W(8)) w_ic ();
  refill_rd_arbiter_if #(.ADDR_W(32), .DATA_W(8)) w_dc ();
  refill_rd_arbiter_if #(.ADDR_W(32), .DATA_W(8)) w_axi ();
  logic [1:0] w_ic_cnt, w_dc_cnt;

  refill_rd_arbiter #(.ADDR_W(32), .DATA_W(8), .CNT_W(2)) dut_w (
    .clk          (clk),
    .resetn       (resetn),
    .ic           (w_ic),
    .dc           (w_dc),
    .axi          (w_axi),
    .ic_grant_cnt (w_ic_cnt),
    .dc_grant_cnt (w_dc_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] d1, d2;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d1 = {8{32'hA5A5_0001}};
    d2 = {8{32'h5A5A_0002}};
    ic_if.rd_req = 0; ic_if.rd_type = 0; ic_if.rd_addr = '0;
    dc_if.rd_req = 0; dc_if.rd_type = 0; dc_if.rd_addr = '0;
    axi_if.rd_rdy = 0; axi_if.ret_valid = 0; axi_if.ret_data = '0;
    w_ic.rd_req = 0; w_ic.rd_type = 0; w_ic.rd_addr = '0;
    w_dc.rd_req = 0; w_dc.rd_type = 0; w_dc.rd_addr = '0;
    w_axi.rd_rdy = 0; w_axi.ret_valid = 0; w_axi.ret_data = '0;

    // Reset: outputs quiet even with a live request and ready bridge
    resetn = 0;
    ic_if.rd_req = 1; ic_if.rd_addr = 32'h1234; axi_if.rd_rdy = 1;
    tick(); tick();
    chk("rst_axi_req", axi_if.rd_req, 0);
    chk("rst_ic_rdy", ic_if.rd_rdy, 0);
    chk("rst_ic_cnt", ic_cnt, 0);
    chk("rst_dc_cnt", dc_cnt, 0);
    resetn = 1; ic_if.rd_req = 0; axi_if.rd_rdy = 0;
    tick();

    // Single IC request accepted immediately, return 3 cycles later
    ic_if.rd_req = 1; ic_if.rd_type = 1; ic_if.rd_addr = 32'h1FC0_0000; axi_if.rd_rdy = 1;
    #1;
    chk("t1_axi_req", axi_if.rd_req, 1);
    chk("t1_axi_addr", axi_if.rd_addr, 32'h1FC0_0000);
    chk("t1_axi_type", axi_if.rd_type, 1);
    chk("t1_ic_rdy", ic_if.rd_rdy, 1);
    chk("t1_dc_rdy", dc_if.rd_rdy, 0);
    tick();
    ic_if.rd_req = 0; axi_if.rd_rdy = 0; #1;
    chk("t1_wait_req", axi_if.rd_req, 0);
    chk("t1_ic_cnt", ic_cnt, 1);
    chk("t1_dc_cnt", dc_cnt, 0);
    tick(); tick();
    axi_if.ret_valid = 1; axi_if.ret_data = d1; #1;
    chk("t1_ic_rv", ic_if.ret_valid, 1);
    chk("t1_ic_data", ic_if.ret_data, d1);
    chk("t1_dc_rv", dc_if.ret_valid, 0);
    tick();
    axi_if.ret_valid = 0; #1;
    chk("t1_ic_rv_off", ic_if.ret_valid, 0);

    // Priority: both request, DC first; simultaneous return + request is return only
    dc_if.rd_req = 1; dc_if.rd_type = 0; dc_if.rd_addr = 32'h8000_1000;
    ic_if.rd_req = 1; ic_if.rd_type = 1; ic_if.rd_addr = 32'h8000_0000;
    axi_if.rd_rdy = 1; #1;
    chk("t2_axi_addr", axi_if.rd_addr, 32'h8000_1000);
    chk("t2_axi_type", axi_if.rd_type, 0);
    chk("t2_dc_rdy", dc_if.rd_rdy, 1);
    chk("t2_ic_rdy", ic_if.rd_rdy, 0);
    tick();
    dc_if.rd_req = 0; #1;
    chk("t2_wait_ic_rdy", ic_if.rd_rdy, 0);
    chk("t2_wait_req", axi_if.rd_req, 0);
    axi_if.ret_valid = 1; axi_if.ret_data = d2; #1;
    chk("t2_dc_rv", dc_if.ret_valid, 1);
    chk("t2_ic_rv", ic_if.ret_valid, 0);
    chk("t2_dc_data", dc_if.ret_data, d2);
    chk("t2_ic_data", ic_if.ret_data, d2);
    chk("t2_sim_ic_rdy", ic_if.rd_rdy, 0);
    tick();
    axi_if.ret_valid = 0; #1;
    chk("t2_ic_rdy_idle", ic_if.rd_rdy, 1);
    chk("t2_ic_addr", axi_if.rd_addr, 32'h8000_0000);
    chk("t2_ic_type", axi_if.rd_type, 1);
    tick();
    ic_if.rd_req = 0; axi_if.rd_rdy = 0; #1;
    chk("t2_ic_cnt", ic_cnt, 2);
    chk("t2_dc_cnt", dc_cnt, 1);
    axi_if.ret_valid = 1; #1;
    chk("t2_ic_rv_ret", ic_if.ret_valid, 1);
    tick();
    axi_if.ret_valid = 0;

    // Grant lock: IC stalled 4 cycles, DC arrives in cycle 2
    ic_if.rd_req = 1; ic_if.rd_addr = 32'h0040_0000;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        dc_if.rd_req = 1; dc_if.rd_addr = 32'h0080_0000;
      end
      #1;
      chk("t3_lock_addr", axi_if.rd_addr, 32'h0040_0000);
      chk("t3_lock_req", axi_if.rd_req, 1);
      chk("t3_lock_dc_rdy", dc_if.rd_rdy, 0);
      tick();
    end
    axi_if.rd_rdy = 1; #1;
    chk("t3_ic_rdy", ic_if.rd_rdy, 1);
    chk("t3_dc_rdy", dc_if.rd_rdy, 0);
    chk("t3_addr", axi_if.rd_addr, 32'h0040_0000);
    tick();
    ic_if.rd_req = 0; #1;
    chk("t3_wait_dc_rdy", dc_if.rd_rdy, 0);
    chk("t3_wait_req", axi_if.rd_req, 0);
    axi_if.ret_valid = 1; #1;
    chk("t3_ic_rv", ic_if.ret_valid, 1);
    chk("t3_dc_rv", dc_if.ret_valid, 0);
    chk("t3_ret_dc_rdy", dc_if.rd_rdy, 0);
    tick();
    axi_if.ret_valid = 0; #1;
    chk("t3_dc_grant", dc_if.rd_rdy, 1);
    chk("t3_dc_addr", axi_if.rd_addr, 32'h0080_0000);
    tick();
    dc_if.rd_req = 0; axi_if.rd_rdy = 0; #1;
    chk("t3_ic_cnt", ic_cnt, 3);
    chk("t3_dc_cnt", dc_cnt, 2);
    axi_if.ret_valid = 1; #1;
    chk("t3_dc_rv_ret", dc_if.ret_valid, 1);
    tick();
    axi_if.ret_valid = 0;

    // Stray returns in IDLE and REQ, then reset in WAIT
    axi_if.ret_valid = 1; #1;
    chk("t4_idle_ic_rv", ic_if.ret_valid, 0);
    chk("t4_idle_dc_rv", dc_if.ret_valid, 0);
    tick();
    axi_if.ret_valid = 0;
    ic_if.rd_req = 1; ic_if.rd_addr = 32'h0000_0100;
    tick();
    axi_if.ret_valid = 1; #1;
    chk("t4_req_ic_rv", ic_if.ret_valid, 0);
    chk("t4_req_dc_rv", dc_if.ret_valid, 0);
    chk("t4_req_axi", axi_if.rd_req, 1);
    axi_if.ret_valid = 0; axi_if.rd_rdy = 1; #1;
    chk("t4_ic_rdy", ic_if.rd_rdy, 1);
    tick();
    ic_if.rd_req = 0; axi_if.rd_rdy = 0;
    resetn = 0; axi_if.ret_valid = 1; #1;
    chk("t4_rst_ic_rv", ic_if.ret_valid, 0);
    tick();
    resetn = 1; #1;
    chk("t4_post_ic_rv", ic_if.ret_valid, 0);
    chk("t4_post_dc_rv", dc_if.ret_valid, 0);
    chk("t4_post_ic_cnt", ic_cnt, 0);
    tick();
    axi_if.ret_valid = 0;
    dc_if.rd_req = 1; dc_if.rd_addr = 32'h0000_0200; axi_if.rd_rdy = 1; #1;
    chk("t4_dc_rdy", dc_if.rd_rdy, 1);
    chk("t4_dc_addr", axi_if.rd_addr, 32'h0000_0200);
    tick();
    dc_if.rd_req = 0; axi_if.rd_rdy = 0; #1;
    chk("t4_dc_cnt", dc_cnt, 1);
    axi_if.ret_valid = 1; #1;
    chk("t4_dc_rv", dc_if.ret_valid, 1);
    tick();
    axi_if.ret_valid = 0;

    // Both requesters continuously after a fresh reset
    resetn = 0; tick(); resetn = 1; tick();
    ic_if.rd_req = 1; ic_if.rd_addr = 32'h0000_1000;
    dc_if.rd_req = 1; dc_if.rd_addr = 32'h0000_2000;
    axi_if.rd_rdy = 1;
`ifdef REFILL_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_dc_rdy", dc_if.rd_rdy, (i % 2 == 0) ? 1 : 0);
      chk("rr_ic_rdy", ic_if.rd_rdy, (i % 2 == 0) ? 0 : 1);
      chk("rr_addr", axi_if.rd_addr, (i % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
      tick();
      axi_if.ret_valid = 1;
      tick();
      axi_if.ret_valid = 0;
    end
    ic_if.rd_req = 0; dc_if.rd_req = 0; axi_if.rd_rdy = 0; #1;
    chk("rr_ic_cnt", ic_cnt, 2);
    chk("rr_dc_cnt", dc_cnt, 2);
`else
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fx_dc_rdy", dc_if.rd_rdy, 1);
      chk("fx_ic_rdy", ic_if.rd_rdy, 0);
      tick();
      axi_if.ret_valid = 1; #1;
      chk("fx_ret_ic_rdy", ic_if.rd_rdy, 0);
      chk("fx_dc_rv", dc_if.ret_valid, 1);
      tick();
      axi_if.ret_valid = 0;
    end
    ic_if.rd_req = 0; dc_if.rd_req = 0; axi_if.rd_rdy = 0; #1;
    chk("fx_ic_cnt", ic_cnt, 0);
    chk("fx_dc_cnt", dc_cnt, 3);
`endif
    tick();

    // Counter wrap on the 2-bit-counter instance: 1, 2, 3, 0
    w_dc.rd_req = 1; w_axi.rd_rdy = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("wrap_dc_rdy", w_dc.rd_rdy, 1);
      tick();
      w_axi.ret_valid = 1; #1;
      chk("wrap_dc_cnt", w_dc_cnt, (i == 4) ? 0 : i);
      tick();
      w_axi.ret_valid = 0;
    end
    w_dc.rd_req = 0; w_axi.rd_rdy = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/refill_rd_arbiter.md
Name: refill_rd_arbiter

Overview:
- Shares the single 256-bit AXI refill read port between the instruction cache and the data-side path (dcache behind its prefetcher).
- Allows one outstanding read at a time.
- Locks the grant from request issue until the data return, and routes the return beat to the owner.
- Sits between the two cache-side read interfaces and the AXI bridge's read request/return interface.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 256, return data width; the full beat is forwarded to the owner.
- CNT_W, 32, width of the per-requester grant counters.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- ic_rd_req  in  1  icache read request
- ic_rd_type  in  1  icache request type; passed through
- ic_rd_addr  in  ADDR_W  icache request address
- ic_rd_rdy  out  1  icache request accepted this cycle
- ic_ret_valid  out  1  icache return beat valid
- ic_ret_data  out  DATA_W  icache return data
- dc_rd_req  in  1  data-side read request
- dc_rd_type  in  1  data-side request type
- dc_rd_addr  in  ADDR_W  data-side request address
- dc_rd_rdy  out  1  data-side request accepted this cycle
- dc_ret_valid  out  1  data-side return beat valid
- dc_ret_data  out  DATA_W  data-side return data
- axi_rd_req  out  1  request to the AXI bridge
- axi_rd_type  out  1  type of the owner's request
- axi_rd_addr  out  ADDR_W  address of the owner's request
- axi_rd_rdy  in  1  bridge accepts the request
- axi_ret_valid  in  1  single-beat return valid
- axi_ret_data  in  DATA_W  return data
- ic_grant_cnt  out  CNT_W  icache requests accepted (wraps)
- dc_grant_cnt  out  CNT_W  data-side requests accepted (wraps)

Behaviour:
- Handshakes:
  - A requester holds req, type and addr stable until it sees rdy high in the same cycle.
  - A transfer happens when req && rdy.
  - A downstream accept happens when axi_rd_req && axi_rd_rdy.
- States: IDLE, REQ (owner locked, waiting for axi_rd_rdy), WAIT (request accepted, waiting for the return). owner is a 1-bit register: 0 = IC, 1 = DC.
- IDLE:
  - Winner is DC if dc_rd_req, else IC if ic_rd_req; there is no winner if neither requests.
  - With a winner: axi_rd_req=1, and axi_rd_type/axi_rd_addr are the winner's values (combinational pass-through).
  - The winner's rdy equals axi_rd_rdy; the loser's rdy is 0.
  - owner is loaded with the winner.
  - Next state is WAIT if axi_rd_rdy, else REQ.
  - With no winner, axi_rd_req=0 and the FSM stays in IDLE.
- REQ:
  - axi_rd_req=1 with the owner's type/addr; the owner is not re-arbitrated, even if a higher-priority requester arrives.
  - Owner rdy equals axi_rd_rdy; the other rdy is 0.
  - On accept, go to WAIT.
- WAIT:
  - axi_rd_req=0 and both rdy=0.
  - On axi_ret_valid, the owner's ret_valid=1 in the same cycle (combinational) and the FSM goes to IDLE.
  - The earliest next request acceptance is the following cycle.
- Return routing:
  - ic_ret_data and dc_ret_data are both driven from axi_ret_data at all times; only the ret_valid signals are gated.
  - A non-owner's ret_valid is always 0.
- Stray returns: axi_ret_valid in IDLE or REQ is dropped; neither ret_valid asserts.
- Counters:
  - Increment by 1 on each accept for the owner of that accept.
  - Wrap from 2^CNT_W-1 to 0.
- Reset:
  - Values: state=IDLE, owner=IC, last_grant=IC, counters=0.
  - All outputs are 0 during reset: axi_rd_req, both rdy, both ret_valid.
  - Reset asserted in REQ or WAIT abandons the transaction. A return arriving after reset is a stray and is dropped.
- Simultaneous events: a return in WAIT and a new request in the same cycle are handled as the return only; the request is arbitrated next cycle in IDLE.

Optional Feature:
- Macro: REFILL_ARB_RR_EN.
- Defined: round-robin arbitration in IDLE.
  - When both requesters ask, the grant goes to the requester that is not last_grant.
  - last_grant is updated on every accept.
  - Because last_grant resets to IC, the first tie goes to DC.
  - A single requester is granted regardless of last_grant.
- Not defined: fixed priority, DC over IC; last_grant is absent.

Test Plan:
- Single requester, accepted immediately: ic_rd_req, addr 0x1FC00000, axi_rd_rdy=1 -> axi_rd_addr=0x1FC00000 and ic_rd_rdy=1 in the same cycle. A return 3 cycles later with data D -> ic_ret_valid=1, ic_ret_data=D, dc_ret_valid=0. ic_grant_cnt=1.
- Priority: both requesters in IDLE, DC addr 0x80001000, IC addr 0x80000000 -> DC granted first. IC granted in IDLE after DC's return. Fixed build: IC rdy stays 0 while DC requests continuously.
- Grant lock: IC requests with axi_rd_rdy=0 for 4 cycles; DC asserts in cycle 2 -> axi_rd_addr stays IC's for all 4 cycles; dc_rd_rdy=0 until IC's return completes.
- Stray return and mid-operation reset: axi_ret_valid in IDLE -> no ret_valid. Reset in WAIT, then axi_ret_valid -> dropped; next request proceeds normally.
- Counter wrap: force dc_grant_cnt=0xFFFFFFFF, one DC accept -> 0x00000000.
- REFILL_ARB_RR_EN: both requesters continuously, 4 accepts -> order DC, IC, DC, IC; each counter = 2.
